rf_writeback_ctrl: RTL and testbench
====================================

RF_WRITEBACK_CTRL -- requirements
Module: rf_writeback_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and reset.
REQ-002 Parameter ADDR_W, 5, register address width.
REQ-003 Parameter DATA_W, 32, register data width.
REQ-004 Parameter LQ_DEPTH, 2, load-result queue depth (>=1).
REQ-005 Ports SHALL be as follows:
  clk  in  1  rising-edge clock
  reset  in  1  async active-high reset
  alu_valid / alu_ready  in / out  1 / 1  ALU result handshake
  alu_rd / alu_data  in  ADDR_W / DATA_W  ALU destination, value
  ld_valid / ld_ready  in / out  1 / 1  load result handshake
  ld_rd / ld_data  in  ADDR_W / DATA_W  load destination, value
  iss_ld_valid / iss_ld_rd  in  1 / ADDR_W  load issued, marks rd pending
  rs_a / rs_b  in  ADDR_W  hazard query addresses
  busy_a / busy_b  out  1  pending-load flags for rs_a / rs_b
  write_enable  out  1  register-file write strobe
  write_address / write_data  out  ADDR_W / DATA_W  write port to register_file

Function
REQ-006 A transfer SHALL occur on a rising edge where valid and ready are both 1.
REQ-007 write_enable, write_address and write_data SHALL be registered; an ALU transfer at edge T SHALL appear on the write port for exactly the cycle after T.
REQ-008 Load transfers SHALL enter a FIFO of LQ_DEPTH entries; earliest write-port appearance is after edge T+1.
REQ-009 ld_ready SHALL equal (count < LQ_DEPTH).
REQ-010 Arbitration per cycle: count==LQ_DEPTH -> pop FIFO head, alu_ready=0; else alu_valid -> write ALU result, alu_ready=1; else count>0 -> pop FIFO head; else write_enable=0 next cycle.
REQ-011 alu_ready SHALL be 1 whenever count < LQ_DEPTH, independent of alu_valid.
REQ-012 A FIFO push and pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-013 Any result with rd==0 SHALL complete its handshake but SHALL NOT assert write_enable.
REQ-014 busy[rd] SHALL set on iss_ld_valid (rd!=0) and clear when a load-sourced write to rd is driven on the write port; same-cycle set and clear of one rd -> set wins.
REQ-015 busy_a/busy_b SHALL be combinational reads of busy[rs_a]/busy[rs_b]; address 0 always returns 0.
REQ-016 Data width arithmetic: none; data SHALL pass unmodified, addresses SHALL not wrap or be truncated.

Reset
REQ-017 On reset: FIFO count=0, busy[*]=0, write_enable=0, write_address=0, write_data=0; ld_ready=1, alu_ready=1 after release.
REQ-018 Reset mid-operation SHALL discard queued loads and in-flight write without a partial write-port pulse.

Configuration
REQ-019 With WB_BYPASS_EN defined, outputs byp_hit_a, byp_hit_b (1) and byp_data_a, byp_data_b (DATA_W) SHALL exist: hit=write_enable && write_address==rs_x && rs_x!=0, data=write_data.
REQ-020 Without WB_BYPASS_EN, those ports and their logic SHALL be absent.

Structure
REQ-021 A shared package SHALL hold ADDR_W/DATA_W defaults and the write-port source enum (SRC_NONE, SRC_ALU, SRC_LD).
REQ-022 The load FIFO SHALL be one sub-module, wb_load_fifo (push/pop/count/head).

Verification
REQ-023 ALU only: rd=5, data=0x0000000C at edge T -> write_enable=1, addr=5, data=0xC in cycle T+1 only.
REQ-024 Load vs ALU: load rd=3 at T, ALU rd=7 valid T+1..T+3 -> writes 7,7,7 then 3; ld_ready stays 1.
REQ-025 Queue full (LQ_DEPTH=2): two loads queued, ALU valid -> alu_ready=0, FIFO drains in order, alu_ready returns to 1 when count<2.
REQ-026 x0: ALU rd=0 data=0xFFFFFFFF -> alu handshake completes, write_enable stays 0.
REQ-027 Scoreboard: iss_ld rd=9, rs_a=9 -> busy_a=1 until load rd=9 written; re-issue on same cycle as write -> busy_a stays 1.
REQ-028 Reset with 2 queued loads -> count=0, no write pulse, busy all 0; with WB_BYPASS_EN, byp_hit_a=1 when write_address==rs_a==4.

Source files
------------

// File: rtl/rf_writeback_ctrl_pkg.sv
// Shared defaults, write-port source encoding and width helpers for the
// register-file writeback controller.
package rf_writeback_ctrl_pkg;

    localparam int ADDR_W_DEF   = 5;
    localparam int DATA_W_DEF   = 32;
    localparam int LQ_DEPTH_DEF = 2;

    // Which producer owns the write port in a given cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LD   = 2'd2
    } wb_src_e;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rf_writeback_ctrl_load_fifo.sv
// wb_load_fifo: small circular queue holding load results (rd, data) until
// the writeback port can take them. Push is ignored when full, pop when empty.
module wb_load_fifo
    import rf_writeback_ctrl_pkg::*;
#(
    parameter int DEPTH  = LQ_DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_push,
    input  logic [ADDR_W-1:0]            i_push_rd,
    input  logic [DATA_W-1:0]            i_push_data,
    input  logic                         i_pop,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic [ADDR_W-1:0]            o_head_rd,
    output logic [DATA_W-1:0]            o_head_data
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] r_rd   [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_push = i_push && (r_count != CNT_W'(DEPTH));
    assign w_pop  = i_pop && (r_count != '0);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= ptr_inc(r_wptr);
            if (w_pop)  r_rptr <= ptr_inc(r_rptr);
            // Simultaneous push and pop leaves the fill level unchanged.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_rd[r_wptr]   <= i_push_rd;
            r_data[r_wptr] <= i_push_data;
        end
    end

    assign o_count     = r_count;
    assign o_head_rd   = r_rd[r_rptr];
    assign o_head_data = r_data[r_rptr];

endmodule

// File: rtl/rf_writeback_ctrl.sv
// Register-file writeback arbiter: ALU results vs queued load results, plus a
// pending-load scoreboard. Define WB_BYPASS_EN to add write-port bypass outputs.
module rf_writeback_ctrl
    import rf_writeback_ctrl_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LQ_DEPTH = LQ_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_rd,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              iss_ld_valid,
    input  logic [ADDR_W-1:0] iss_ld_rd,
    input  logic [ADDR_W-1:0] rs_a,
    input  logic [ADDR_W-1:0] rs_b,
    output logic              busy_a,
    output logic              busy_b,
    output logic              write_enable,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] write_data
`ifdef WB_BYPASS_EN
    ,
    output logic              byp_hit_a,
    output logic              byp_hit_b,
    output logic [DATA_W-1:0] byp_data_a,
    output logic [DATA_W-1:0] byp_data_b
`endif
);

    localparam int CNT_W = cnt_w(LQ_DEPTH);
    localparam int NREGS = 1 << ADDR_W;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both 1; ready depends only on the load-queue fill level, never on valid.

    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_ld_push;
    logic              w_pop;
    wb_src_e           w_src;
    logic [ADDR_W-1:0] w_sel_rd;
    logic [DATA_W-1:0] w_sel_data;
    logic [ADDR_W-1:0] w_head_rd;
    logic [DATA_W-1:0] w_head_data;

    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    wb_src_e           r_src;
    logic [NREGS-1:0]  r_busy;

    assign w_full    = (w_count == CNT_W'(LQ_DEPTH));
    assign ld_ready  = !w_full;
    assign alu_ready = !w_full;
    assign w_ld_push = ld_valid && ld_ready;

    wb_load_fifo #(
        .DEPTH  (LQ_DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_load_fifo (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_push      (w_ld_push),
        .i_push_rd   (ld_rd),
        .i_push_data (ld_data),
        .i_pop       (w_pop),
        .o_count     (w_count),
        .o_head_rd   (w_head_rd),
        .o_head_data (w_head_data)
    );

    // A full queue must drain first; otherwise the ALU wins over queued loads.
    always_comb begin
        w_src      = SRC_NONE;
        w_pop      = 1'b0;
        w_sel_rd   = '0;
        w_sel_data = '0;
        if (w_full) begin
            w_src      = SRC_LD;
            w_pop      = 1'b1;
            w_sel_rd   = w_head_rd;
            w_sel_data = w_head_data;
        end else if (alu_valid) begin
            w_src      = SRC_ALU;
            w_sel_rd   = alu_rd;
            w_sel_data = alu_data;
        end else if (w_count != '0) begin
            w_src      = SRC_LD;
            w_pop      = 1'b1;
            w_sel_rd   = w_head_rd;
            w_sel_data = w_head_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
            r_src  <= SRC_NONE;
        end else begin
            r_we   <= (w_src != SRC_NONE) && (w_sel_rd != '0);
            r_addr <= w_sel_rd;
            r_data <= w_sel_data;
            r_src  <= w_src;
        end
    end

    // Clear comes from the load write currently on the port; a new issue to
    // the same rd in that cycle is assigned later and therefore wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            if (r_we && (r_src == SRC_LD)) r_busy[r_addr] <= 1'b0;
            if (iss_ld_valid && (iss_ld_rd != '0)) r_busy[iss_ld_rd] <= 1'b1;
        end
    end

    assign busy_a = (rs_a != '0) && r_busy[rs_a];
    assign busy_b = (rs_b != '0) && r_busy[rs_b];

    assign write_enable  = r_we;
    assign write_address = r_addr;
    assign write_data    = r_data;

`ifdef WB_BYPASS_EN
    assign byp_hit_a  = r_we && (r_addr == rs_a) && (rs_a != '0);
    assign byp_hit_b  = r_we && (r_addr == rs_b) && (rs_b != '0);
    assign byp_data_a = r_data;
    assign byp_data_b = r_data;
`endif

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Testbench for rf_writeback_ctrl: directed vectors, a queue-based reference
// model compared every cycle, and hand-computed literal checks.
module tb_rf_writeback_ctrl;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int LQ = 2;
    localparam int NREGS = 1 << AW;

    logic          clk;
    logic          reset;
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_rd;
    logic [DW-1:0] ld_data;
    logic          iss_ld_valid;
    logic [AW-1:0] iss_ld_rd;
    logic [AW-1:0] rs_a;
    logic [AW-1:0] rs_b;
    logic          busy_a;
    logic          busy_b;
    logic          write_enable;
    logic [AW-1:0] write_address;
    logic [DW-1:0] write_data;
`ifdef WB_BYPASS_EN
    logic          byp_hit_a;
    logic          byp_hit_b;
    logic [DW-1:0] byp_data_a;
    logic [DW-1:0] byp_data_b;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    rf_writeback_ctrl #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .LQ_DEPTH (LQ)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_rd         (ld_rd),
        .ld_data       (ld_data),
        .iss_ld_valid  (iss_ld_valid),
        .iss_ld_rd     (iss_ld_rd),
        .rs_a          (rs_a),
        .rs_b          (rs_b),
        .busy_a        (busy_a),
        .busy_b        (busy_b),
        .write_enable  (write_enable),
        .write_address (write_address),
        .write_data    (write_data)
`ifdef WB_BYPASS_EN
        ,
        .byp_hit_a     (byp_hit_a),
        .byp_hit_b     (byp_hit_b),
        .byp_data_a    (byp_data_a),
        .byp_data_b    (byp_data_b)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // exp_q holds queued loads as {rd, data}; the write port expectation is
    // what must be visible during the cycle after each edge.
    logic [AW+DW-1:0] exp_q[$];
    logic             m_we;
    logic [AW-1:0]    m_addr;
    logic [DW-1:0]    m_data;
    logic             m_src_ld;
    logic [NREGS-1:0] m_busy;
    logic [AW+DW-1:0] m_e;
    logic             m_have;
    logic             m_full;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            m_we     = 1'b0;
            m_addr   = '0;
            m_data   = '0;
            m_src_ld = 1'b0;
            m_busy   = '0;
        end else begin
            if (m_we && m_src_ld) m_busy[m_addr] = 1'b0;
            if (iss_ld_valid && iss_ld_rd != 0) m_busy[iss_ld_rd] = 1'b1;
            m_full = (exp_q.size() == LQ);
            m_have = 1'b0;
            if (m_full || (!alu_valid && exp_q.size() > 0)) begin
                m_e      = exp_q.pop_front();
                m_addr   = m_e[AW+DW-1:DW];
                m_data   = m_e[DW-1:0];
                m_src_ld = 1'b1;
                m_have   = 1'b1;
            end else if (alu_valid) begin
                m_addr   = alu_rd;
                m_data   = alu_data;
                m_src_ld = 1'b0;
                m_have   = 1'b1;
            end else begin
                m_src_ld = 1'b0;
            end
            if (!m_full && ld_valid) exp_q.push_back({ld_rd, ld_data});
            m_we = m_have && (m_addr != 0);
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc write_enable", 64'(write_enable), 64'(m_we));
            if (m_we) begin
                chk("cyc write_address", 64'(write_address), 64'(m_addr));
                chk("cyc write_data", 64'(write_data), 64'(m_data));
            end
            chk("cyc ld_ready", 64'(ld_ready), 64'(exp_q.size() < LQ));
            chk("cyc alu_ready", 64'(alu_ready), 64'(exp_q.size() < LQ));
            chk("cyc busy_a", 64'(busy_a), 64'(rs_a != 0 && m_busy[rs_a]));
            chk("cyc busy_b", 64'(busy_b), 64'(rs_b != 0 && m_busy[rs_b]));
`ifdef WB_BYPASS_EN
            chk("cyc byp_hit_a", 64'(byp_hit_a), 64'(m_we && m_addr == rs_a && rs_a != 0));
            chk("cyc byp_hit_b", 64'(byp_hit_b), 64'(m_we && m_addr == rs_b && rs_b != 0));
            if (m_we) chk("cyc byp_data_a", 64'(byp_data_a), 64'(m_data));
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        alu_valid    = 1'b0;
        alu_rd       = '0;
        alu_data     = '0;
        ld_valid     = 1'b0;
        ld_rd        = '0;
        ld_data      = '0;
        iss_ld_valid = 1'b0;
        iss_ld_rd    = '0;
    endtask

    task automatic drive_alu(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
        alu_valid = v;
        alu_rd    = rd;
        alu_data  = d;
    endtask

    task automatic drive_ld(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
        ld_valid = v;
        ld_rd    = rd;
        ld_data  = d;
    endtask

    task automatic drive_iss(input logic v, input logic [AW-1:0] rd);
        iss_ld_valid = v;
        iss_ld_rd    = rd;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset = 1'b1;
        idle_inputs();
        rs_a = '0;
        rs_b = '0;
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst write_enable", 64'(write_enable), 64'd0);
        chk("rst write_address", 64'(write_address), 64'd0);
        chk("rst write_data", 64'(write_data), 64'd0);
        reset = 1'b0;
        chk("rst ld_ready", 64'(ld_ready), 64'd1);
        chk("rst alu_ready", 64'(alu_ready), 64'd1);

        // ALU only: one-cycle write pulse
        drive_alu(1'b1, 5'd5, 32'h0000000C);
        tick();
        chk("alu we", 64'(write_enable), 64'd1);
        chk("alu addr", 64'(write_address), 64'd5);
        chk("alu data", 64'(write_data), 64'hC);
        drive_alu(1'b0, '0, '0);
        tick();
        chk("alu pulse end", 64'(write_enable), 64'd0);

        // Load waits behind three ALU writes
        drive_ld(1'b1, 5'd3, 32'h33);
        tick();
        drive_ld(1'b0, '0, '0);
        drive_alu(1'b1, 5'd7, 32'h77);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ld-vs-alu addr7", 64'(write_address), 64'd7);
            chk("ld-vs-alu ld_ready", 64'(ld_ready), 64'd1);
        end
        drive_alu(1'b0, '0, '0);
        tick();
        chk("ld-vs-alu addr3", 64'(write_address), 64'd3);
        chk("ld-vs-alu data", 64'(write_data), 64'h33);
        tick();
        chk("ld-vs-alu idle", 64'(write_enable), 64'd0);

        // Queue full: ALU stalls, FIFO drains in order
        drive_alu(1'b1, 5'd1, 32'h100);
        drive_ld(1'b1, 5'd10, 32'hA0);
        tick();
        drive_ld(1'b1, 5'd11, 32'hB1);
        tick();
        drive_ld(1'b0, '0, '0);
        chk("full alu_ready", 64'(alu_ready), 64'd0);
        chk("full ld_ready", 64'(ld_ready), 64'd0);
        tick();
        chk("full drain1 addr", 64'(write_address), 64'd10);
        chk("full drain1 data", 64'(write_data), 64'hA0);
        chk("full alu_ready back", 64'(alu_ready), 64'd1);
        tick();
        chk("full alu after", 64'(write_address), 64'd1);
        drive_alu(1'b0, '0, '0);
        tick();
        chk("full drain2 addr", 64'(write_address), 64'd11);
        chk("full drain2 data", 64'(write_data), 64'hB1);
        tick();

        // x0 results complete but never write
        drive_alu(1'b1, 5'd0, 32'hFFFFFFFF);
        chk("x0 alu_ready", 64'(alu_ready), 64'd1);
        tick();
        drive_alu(1'b0, '0, '0);
        chk("x0 alu we", 64'(write_enable), 64'd0);
        drive_ld(1'b1, 5'd0, 32'h12345678);
        tick();
        drive_ld(1'b0, '0, '0);
        tick();
        chk("x0 ld we", 64'(write_enable), 64'd0);

        // Scoreboard set/clear, re-issue during the write wins
        rs_a = 5'd9;
        rs_b = 5'd0;
        drive_iss(1'b1, 5'd9);
        tick();
        drive_iss(1'b1, 5'd0);
        chk("sb busy set", 64'(busy_a), 64'd1);
        drive_ld(1'b1, 5'd9, 32'h99);
        tick();
        drive_iss(1'b0, '0);
        drive_ld(1'b0, '0, '0);
        chk("sb busy_b x0", 64'(busy_b), 64'd0);
        tick();
        chk("sb write9", 64'(write_address), 64'd9);
        chk("sb busy during write", 64'(busy_a), 64'd1);
        drive_iss(1'b1, 5'd9);
        tick();
        drive_iss(1'b0, '0);
        chk("sb reissue wins", 64'(busy_a), 64'd1);
        drive_ld(1'b1, 5'd9, 32'h98);
        tick();
        drive_ld(1'b0, '0, '0);
        tick();
        chk("sb write9 again", 64'(write_data), 64'h98);
        tick();
        chk("sb busy cleared", 64'(busy_a), 64'd0);

        // Mixed traffic table, checked by the model every cycle
        for (int i = 0; i < 16; i++) begin
            drive_alu((i % 3) != 2, AW'(i + 1), 32'h1000 + 32'(i));
            drive_ld((i % 2) == 0, AW'(20 + i % 8), 32'h2000 + 32'(i));
            drive_iss((i % 4) == 1, AW'(20 + i % 8));
            rs_a = AW'(20 + i % 8);
            rs_b = AW'(21 + i % 8);
            tick();
        end
        idle_inputs();
        repeat (4) tick();

        // Reset mid-operation with two queued loads
        rs_a = 5'd4;
        rs_b = 5'd6;
        drive_iss(1'b1, 5'd4);
        tick();
        drive_iss(1'b1, 5'd6);
        tick();
        drive_iss(1'b0, '0);
        drive_alu(1'b1, 5'd2, 32'h22);
        drive_ld(1'b1, 5'd4, 32'h44);
        tick();
        drive_ld(1'b1, 5'd6, 32'h66);
        tick();
        idle_inputs();
        chk("pre-rst ld_ready", 64'(ld_ready), 64'd0);
        reset = 1'b1;
        #1;
        chk("mid-rst we", 64'(write_enable), 64'd0);
        chk("mid-rst addr", 64'(write_address), 64'd0);
        chk("mid-rst ld_ready", 64'(ld_ready), 64'd1);
        chk("mid-rst busy_a", 64'(busy_a), 64'd0);
        chk("mid-rst busy_b", 64'(busy_b), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("post-rst no pulse1", 64'(write_enable), 64'd0);
        tick();
        chk("post-rst no pulse2", 64'(write_enable), 64'd0);

`ifdef WB_BYPASS_EN
        drive_alu(1'b1, 5'd4, 32'h0000ABCD);
        tick();
        drive_alu(1'b0, '0, '0);
        chk("byp hit_a", 64'(byp_hit_a), 64'd1);
        chk("byp data_a", 64'(byp_data_a), 64'hABCD);
        chk("byp hit_b", 64'(byp_hit_b), 64'd0);
        tick();
        chk("byp hit_a off", 64'(byp_hit_a), 64'd0);
`endif

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
